// File: rtl/hex_avalon_slave_pkg.sv
// ============================================================================
// Module  : hex_avalon_slave_pkg
// Purpose : Shared register map, segment codes and conversion FSM states for
//           the six-digit seven-segment Avalon slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hex_avalon_slave_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_DEC   = 0;
    localparam int CTRL_LZB   = 1;
    localparam int CTRL_BLINK = 2;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'h3F;
    localparam logic [19:0] DEC_MAX   = 20'd999999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] nib2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_avalon_slave_bin2bcd.sv
// ============================================================================
// Module  : bin2bcd_seq
// Purpose : Sequential shift-add-3 binary-to-BCD converter, one bit per cycle,
//           restartable at any time by start and cancellable by abort.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import hex_avalon_slave_pkg::*;
#(
    parameter int BIN_W = 20,
    parameter int BCD_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int             CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    conv_state_t      state_q, state_d;
    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] sh_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A new start wins over everything so a rewrite always restarts cleanly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == LAST_BIT) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
        if (start) state_d = ST_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (start) bin_q <= bin;
            case (state_q)
                ST_LOAD: begin
                    sh_q  <= bin_q;
                    bcd_q <= '0;
                    cnt_q <= '0;
                end
                ST_SHIFT: begin
                    {bcd_q, sh_q} <= {adj[BCD_W-2:0], sh_q, 1'b0};
                    cnt_q         <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_COMMIT);
    assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/hex_avalon_slave.sv
// ============================================================================
// Module  : hex_avalon_slave
// Purpose : Avalon-MM slave driving six seven-segment digits in hex or
//           decimal form, with leading-zero blanking and blinking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_avalon_slave
    import hex_avalon_slave_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [6:0]  to_hex_0_readdata,
    output logic [6:0]  to_hex_1_readdata,
    output logic [6:0]  to_hex_2_readdata,
    output logic [6:0]  to_hex_3_readdata,
    output logic [6:0]  to_hex_4_readdata,
    output logic [6:0]  to_hex_5_readdata
);

    localparam logic [31:0] DIV_RST = 32'(CLK_HZ / 2);

    logic [23:0] data_q;
    logic [2:0]  ctrl_q;
    logic [31:0] div_q;
    logic [23:0] shown_q;
    logic        dash_q;
    logic [31:0] cnt_q;
    logic        phase_q;

    logic        wr_data, wr_ctrl, wr_div;
    logic [23:0] new_data;
    logic [2:0]  new_ctrl;
    logic        conv_start, conv_abort, hex_load, commit;
    logic        busy, done;
    logic [23:0] bcd;

    assign wr_data  = avs_write && (avs_address == ADDR_DATA);
    assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign wr_div   = avs_write && (avs_address == ADDR_DIV);
    assign new_data = wr_data ? avs_writedata[23:0] : data_q;
    assign new_ctrl = wr_ctrl ? avs_writedata[2:0]  : ctrl_q;

    assign conv_start = (wr_data || wr_ctrl) &&  new_ctrl[CTRL_DEC];
    assign conv_abort = wr_ctrl && !new_ctrl[CTRL_DEC];
    assign hex_load   = (wr_data || wr_ctrl) && !new_ctrl[CTRL_DEC];
    // A result finishing on the same edge as a rewrite is stale; drop it.
    assign commit     = done && !conv_start && !conv_abort;

    bin2bcd_seq #(
        .BIN_W (20),
        .BCD_W (24)
    ) u_bin2bcd (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .start (conv_start),
        .abort (conv_abort),
        .bin   (new_data[19:0]),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            div_q   <= DIV_RST;
            shown_q <= '0;
            dash_q  <= 1'b0;
        end else begin
            if (wr_data) data_q <= avs_writedata[23:0];
            if (wr_ctrl) ctrl_q <= avs_writedata[2:0];
            if (wr_div)  div_q  <= avs_writedata;
            if (hex_load) begin
                shown_q <= new_data;
                dash_q  <= 1'b0;
            end else if (commit) begin
                shown_q <= bcd;
                dash_q  <= (data_q[19:0] > DEC_MAX);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (wr_div || (div_q == 32'd0)) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == div_q - 32'd1) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_DATA:   avs_readdata <= {8'd0, data_q};
                ADDR_CTRL:   avs_readdata <= {29'd0, ctrl_q};
                ADDR_DIV:    avs_readdata <= div_q;
                default:     avs_readdata <= {31'd0, busy};
            endcase
        end
    end

    logic [41:0] seg_vec;
    logic [3:0]  digit;
    logic [6:0]  seg;
    logic        lead;

    // Walk from the top digit down; lead stays set while every digit so far is 0.
    always_comb begin
        seg_vec = '0;
        digit   = '0;
        seg     = SEG_BLANK;
        lead    = ctrl_q[CTRL_LZB] && !dash_q;
        for (int k = 5; k >= 0; k--) begin
            digit = shown_q[4*k +: 4];
            if (dash_q) begin
                seg = SEG_DASH;
            end else if (lead && (digit == 4'd0) && (k != 0)) begin
                seg = SEG_BLANK;
            end else begin
                seg = nib2seg(digit);
            end
            if (digit != 4'd0) lead = 1'b0;
            if (ctrl_q[CTRL_BLINK] && phase_q) seg = SEG_BLANK;
            seg_vec[7*k +: 7] = seg;
        end
    end

    assign to_hex_0_readdata = seg_vec[6:0];
    assign to_hex_1_readdata = seg_vec[13:7];
    assign to_hex_2_readdata = seg_vec[20:14];
    assign to_hex_3_readdata = seg_vec[27:21];
    assign to_hex_4_readdata = seg_vec[34:28];
    assign to_hex_5_readdata = seg_vec[41:35];

endmodule

`default_nettype wire

// File: tb/tb_hex_avalon_slave.sv
// ============================================================================
// Module  : tb_hex_avalon_slave
// Purpose : Scoreboard bench for hex_avalon_slave: directed scenarios plus
//           randomized writes, checked against a digit-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hex_avalon_slave;

    localparam int CLK_HZ = 50_000_000;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [6:0]  h0, h1, h2, h3, h4, h5;
    logic [41:0] disp;

    hex_avalon_slave #(.CLK_HZ(CLK_HZ)) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .to_hex_0_readdata (h0),
        .to_hex_1_readdata (h1),
        .to_hex_2_readdata (h2),
        .to_hex_3_readdata (h3),
        .to_hex_4_readdata (h4),
        .to_hex_5_readdata (h5)
    );

    assign disp = {h5, h4, h3, h2, h1, h0};

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_read;
        bit          is_conv;
        logic [41:0] exp;
        int          id;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  nid = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [23:0] m_data;
    logic [2:0]  m_ctrl;
    int          m_div;
    int          blink_w;
    logic [23:0] m_shown;
    bit          m_dash;
    int          conv_n;
    int          conv_val;
    int          last_n;

    function automatic logic [41:0] render(input logic [23:0] digs, input bit dash,
                                           input logic [2:0] ctrl, input bit ph);
        logic [41:0] r;
        int          top;
        r   = '0;
        top = 0;
        for (int k = 0; k < 6; k++) if (digs[4*k +: 4] != 4'd0) top = k;
        for (int k = 0; k < 6; k++) begin
            if (ctrl[2] && ph)          r[7*k +: 7] = 7'h7F;
            else if (dash)              r[7*k +: 7] = 7'h3F;
            else if (ctrl[1] && k > top) r[7*k +: 7] = 7'h7F;
            else                        r[7*k +: 7] = seg_tab[digs[4*k +: 4]];
        end
        return r;
    endfunction

    function automatic void digits_dec(input int v, output logic [23:0] digs, output bit dash);
        int p;
        p    = 1;
        digs = '0;
        dash = (v > 999999);
        if (!dash) begin
            for (int k = 0; k < 6; k++) begin
                digs[4*k +: 4] = 4'((v / p) % 10);
                p = p * 10;
            end
        end
    endfunction

    function automatic bit phase_at(input int e);
        if (m_div == 0) return 1'b0;
        return (((e - blink_w) / m_div) % 2) == 1;
    endfunction

    function automatic logic exp_busy(input int e);
        return (conv_n >= 0) && (e >= conv_n + 1) && (e <= conv_n + 21);
    endfunction

    task automatic push(input int due, input bit is_read, input bit is_conv, input logic [41:0] exp);
        sb.push_back('{due, is_read, is_conv, exp, nid});
        nid++;
    endtask

    task automatic push_disp(input int due, input bit is_conv);
        push(due, 1'b0, is_conv, render(m_shown, m_dash, m_ctrl, phase_at(due)));
    endtask

    task automatic cancel_conv(input int n);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].is_conv && sb[i].due >= n) sb.delete(i);
    endtask

    // Fold a finished conversion into the shown digits, or drop one still in flight.
    task automatic settle(input int n);
        if (conv_n >= 0) begin
            if (conv_n + 22 < n) digits_dec(conv_val, m_shown, m_dash);
            else                 cancel_conv(n);
            conv_n = -1;
        end
    endtask

    task automatic start_conv(input int n);
        logic [23:0] nd;
        bit          ndash;
        conv_n   = n;
        conv_val = int'({12'd0, m_data[19:0]});
        push_disp(n + 21, 1'b1);
        digits_dec(conv_val, nd, ndash);
        push(n + 22, 1'b0, 1'b1, render(nd, ndash, m_ctrl, phase_at(n + 22)));
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] v, input int n);
        if (a == 2'd0 || a == 2'd1) begin
            settle(n);
            if (a == 2'd0) m_data = v[23:0];
            else           m_ctrl = v[2:0];
            if (m_ctrl[0]) begin
                start_conv(n);
            end else begin
                m_shown = m_data;
                m_dash  = 1'b0;
                push_disp(n, 1'b0);
            end
        end else if (a == 2'd2) begin
            m_div   = int'(v);
            blink_w = n;
        end
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_ctrl  = '0;
        m_div   = CLK_HZ / 2;
        blink_w = cyc;
        m_shown = '0;
        m_dash  = 1'b0;
        conv_n  = -1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        last_n        = cyc + 1;
        avs_address   = a;
        avs_writedata = v;
        avs_write     = 1'b1;
        model_write(a, v, last_n);
        @(negedge clk_clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        push(cyc + 1, 1'b1, 1'b0, {10'd0, exp});
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk_clk);
        avs_read    = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_clk);
    endtask

    // Monitor: compare every scoreboard entry that falls due on this cycle.
    always @(negedge clk_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [41:0] act;
                act = sb[i].is_read ? {10'd0, avs_readdata} : disp;
                checks++;
                if (act !== sb[i].exp) begin
                    failures++;
                    $display("FAIL %s#%0d cycle=%0d got=%h exp=%h",
                             sb[i].is_read ? "read" : "disp", sb[i].id, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, w2, w3, guard;
        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        model_reset();

        // Reset state
        push_disp(cyc + 1, 1'b0);
        rd(2'd3, 32'd0);
        rd(2'd2, 32'(CLK_HZ / 2));

        // Hex mode
        wr(2'd0, 32'h0012AB3F);
        rd(2'd0, 32'h0012AB3F);

        // Decimal with leading-zero blanking, BUSY window edges
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd1234);
        n0 = last_n;
        wait_until(n0 + 1);  rd(2'd3, {31'd0, exp_busy(cyc)});
        wait_until(n0 + 20); rd(2'd3, {31'd0, exp_busy(cyc)});
        rd(2'd3, {31'd0, exp_busy(cyc)});
        rd(2'd3, {31'd0, exp_busy(cyc)});
        wait_until(n0 + 24);

        // Abort mid-conversion, then overflow to dashes
        wr(2'd0, 32'd5);
        n0 = last_n;
        wait_until(n0 + 9);
        wr(2'd0, 32'd999999);
        push_disp(n0 + 22, 1'b0);
        wait_until(n0 + 34);
        wr(2'd0, 32'd1000000);
        wait_until(last_n + 24);

        // Blink with divider 4, then divider 0
        wr(2'd2, 32'd4);
        wr(2'd1, 32'd4);
        w2 = last_n;
        for (int e = w2 + 1; e <= w2 + 12; e++) push_disp(e, 1'b0);
        wait_until(w2 + 13);
        wr(2'd2, 32'd0);
        w3 = last_n;
        for (int e = w3 + 1; e <= w3 + 6; e++) push_disp(e, 1'b0);
        wait_until(w3 + 8);

        // Reset in the middle of a conversion
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd4321);
        wait_until(last_n + 11);
        reset_reset_n = 1'b0;
        cancel_conv(0);
        #1;
        checks++;
        if (disp !== {6{7'h40}}) begin
            failures++;
            $display("FAIL reset_mid_conv got=%h exp=%h", disp, {6{7'h40}});
        end
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        model_reset();
        rd(2'd3, 32'd0);
        rd(2'd1, 32'd0);
        push_disp(cyc + 25, 1'b0);
        wait_until(cyc + 27);

        // Randomized mode / data sequences with aborts and boundary values
        for (int it = 0; it < 24; it++) begin
            logic dc, lz;
            int   sel, d, k;
            dc  = 1'($urandom % 2);
            lz  = 1'($urandom % 2);
            sel = int'($urandom % 6);
            case (sel)
                0:       d = int'($urandom % 1000);
                1:       d = 999999;
                2:       d = 1000000;
                3:       d = int'($urandom % 32'h100000);
                4:       d = 0;
                default: d = int'($urandom % 32'h1000000);
            endcase
            wr(2'd1, {29'd0, 1'b0, lz, dc});
            k = int'($urandom_range(0, 26));
            wait_until(cyc + k);
            wr(2'd0, 32'(d));
            if (dc) begin
                wait_until(last_n + int'($urandom_range(0, 21)));
                rd(2'd3, {31'd0, exp_busy(cyc)});
                rd(2'd0, {8'd0, m_data});
                wait_until(last_n + 24);
            end else begin
                rd(2'd1, {29'd0, m_ctrl});
                wait_until(cyc + 2);
            end
        end

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk_clk);
            guard++;
        end
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL timeout#%0d due=%0d exp=%h never compared", sb[i].id, sb[i].due, sb[i].exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
